// File: rtl/lsu_mmio.sv
// Load-store unit: DMEM plus memory-mapped I/O, B/H/W lane steering, sign/zero extension.
// Load data registered, valid one cycle after the request; no backpressure, one request per cycle.
module lsu_mmio #(
  parameter int DMEM_WORDS = 2048
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_lsu_valid,
  input  logic        i_lsu_wren,
  input  logic [2:0]  i_lsu_size,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_st_data,
  input  logic [31:0] i_io_sw,
  input  logic [3:0]  i_io_btn,
  output logic [31:0] o_ld_data,
  output logic        o_ld_valid,
  output logic        o_misaligned,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [63:0] o_io_hex,
  output logic [31:0] o_io_lcd
);

  localparam int AW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

  logic [31:0] dmem [DMEM_WORDS];

  logic [31:0] ld_data_q, ld_data_d;
  logic        ld_valid_q, ld_valid_d;
  logic        mis_q, mis_d;
  logic [31:0] ledr_q, ledr_d, ledg_q, ledg_d, lcd_q, lcd_d;
  logic [31:0] hex_lo_q, hex_lo_d, hex_hi_q, hex_hi_d;
  logic [31:0] sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
  logic [3:0]  btn_meta_q, btn_meta_d, btn_sync_q, btn_sync_d;

  logic          upper_zero;
  logic [13:0]   wa;
  logic          hit_dmem, hit_ledr, hit_ledg, hit_hexlo, hit_hexhi, hit_lcd, hit_sw, hit_btn;
  logic          size_legal, aligned, bad;
  logic [3:0]    be;
  logic [31:0]   wmask, wdata, rd_word, shifted, ld_ext;
  logic          st_ok, ld_req, dmem_we;
  logic [AW-1:0] dmem_idx;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nv,
                                        input logic [31:0] m);
    return (old & ~m) | (nv & m);
  endfunction

  always_comb begin
    upper_zero = (i_lsu_addr[31:16] == 16'h0);
    wa         = i_lsu_addr[15:2];
    hit_dmem   = upper_zero && (i_lsu_addr[15:13] == 3'b001);
    hit_ledr   = upper_zero && (wa == 14'h1C00);
    hit_ledg   = upper_zero && (wa == 14'h1C04);
    hit_hexlo  = upper_zero && (wa == 14'h1C08);
    hit_hexhi  = upper_zero && (wa == 14'h1C09);
    hit_lcd    = upper_zero && (wa == 14'h1C0C);
    hit_sw     = upper_zero && (wa == 14'h1E00);
    hit_btn    = upper_zero && (wa == 14'h1E04);
    dmem_idx   = i_lsu_addr[AW+1:2];

    if (i_lsu_wren) size_legal = (i_lsu_size == 3'b000) || (i_lsu_size == 3'b001) ||
                                 (i_lsu_size == 3'b010);
    else            size_legal = (i_lsu_size != 3'b011) && (i_lsu_size != 3'b110) &&
                                 (i_lsu_size != 3'b111);
    case (i_lsu_size[1:0])
      2'b01:   aligned = ~i_lsu_addr[0];
      2'b10:   aligned = (i_lsu_addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    bad = ~size_legal | ~aligned;

    case (i_lsu_size[1:0])
      2'b00: begin
        be    = 4'b0001 << i_lsu_addr[1:0];
        wdata = {4{i_st_data[7:0]}};
      end
      2'b01: begin
        be    = i_lsu_addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{i_st_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = i_st_data;
      end
    endcase
    wmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};

    st_ok   = i_lsu_valid & i_lsu_wren & ~bad & ~i_reset;
    ld_req  = i_lsu_valid & ~i_lsu_wren & ~i_reset;
    dmem_we = st_ok & hit_dmem;

    rd_word = 32'h0;
    if (hit_dmem)  rd_word = dmem[dmem_idx];
    if (hit_ledr)  rd_word = ledr_q;
    if (hit_ledg)  rd_word = ledg_q;
    if (hit_hexlo) rd_word = hex_lo_q;
    if (hit_hexhi) rd_word = hex_hi_q;
    if (hit_lcd)   rd_word = lcd_q;
    if (hit_sw)    rd_word = sw_sync_q;
    if (hit_btn)   rd_word = {28'h0, btn_sync_q};

    shifted = rd_word >> {i_lsu_addr[1:0], 3'b000};
    case (i_lsu_size)
      3'b000:  ld_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ld_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ld_ext = {24'h0, shifted[7:0]};
      3'b101:  ld_ext = {16'h0, shifted[15:0]};
      default: ld_ext = shifted;
    endcase

    ld_valid_d = ld_req;
    ld_data_d  = (ld_req && !bad) ? ld_ext : 32'h0;
    mis_d      = i_lsu_valid & bad;

    ledr_d   = (st_ok && hit_ledr)  ? merge(ledr_q,   wdata, wmask) : ledr_q;
    ledg_d   = (st_ok && hit_ledg)  ? merge(ledg_q,   wdata, wmask) : ledg_q;
    hex_lo_d = (st_ok && hit_hexlo) ? merge(hex_lo_q, wdata, wmask) : hex_lo_q;
    hex_hi_d = (st_ok && hit_hexhi) ? merge(hex_hi_q, wdata, wmask) : hex_hi_q;
    lcd_d    = (st_ok && hit_lcd)   ? merge(lcd_q,    wdata, wmask) : lcd_q;

    sw_meta_d  = i_io_sw;
    sw_sync_d  = sw_meta_q;
    btn_meta_d = i_io_btn;
    btn_sync_d = btn_meta_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ld_data_q  <= 32'h0;
      ld_valid_q <= 1'b0;
      mis_q      <= 1'b0;
      ledr_q     <= 32'h0;
      ledg_q     <= 32'h0;
      hex_lo_q   <= 32'h0;
      hex_hi_q   <= 32'h0;
      lcd_q      <= 32'h0;
      sw_meta_q  <= 32'h0;
      sw_sync_q  <= 32'h0;
      btn_meta_q <= 4'h0;
      btn_sync_q <= 4'h0;
    end else begin
      ld_data_q  <= ld_data_d;
      ld_valid_q <= ld_valid_d;
      mis_q      <= mis_d;
      ledr_q     <= ledr_d;
      ledg_q     <= ledg_d;
      hex_lo_q   <= hex_lo_d;
      hex_hi_q   <= hex_hi_d;
      lcd_q      <= lcd_d;
      sw_meta_q  <= sw_meta_d;
      sw_sync_q  <= sw_sync_d;
      btn_meta_q <= btn_meta_d;
      btn_sync_q <= btn_sync_d;
    end
  end

  // DMEM is never reset; only enabled lanes are written.
  always_ff @(posedge i_clk) begin
    if (dmem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) dmem[dmem_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // A response pending when reset arrives is squashed rather than delivered.
  assign o_ld_valid   = ld_valid_q & ~i_reset;
  assign o_ld_data    = i_reset ? 32'h0 : ld_data_q;
  assign o_misaligned = mis_q & ~i_reset;
  assign o_io_ledr    = ledr_q;
  assign o_io_ledg    = ledg_q;
  assign o_io_hex     = {hex_hi_q, hex_lo_q};
  assign o_io_lcd     = lcd_q;

endmodule

// File: tb/tb_lsu_mmio.sv
// Directed plus randomized bench for lsu_mmio against a byte-addressed memory/register model.
module tb_lsu_mmio;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_valid, lsu_wren;
  logic [2:0]  lsu_size;
  logic [31:0] lsu_addr, st_data, io_sw;
  logic [3:0]  io_btn;
  logic [31:0] ld_data, io_ledr, io_ledg, io_lcd;
  logic        ld_valid, misaligned;
  logic [63:0] io_hex;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mm [0:8191];
  logic [31:0] ledr_m, ledg_m, hexlo_m, hexhi_m, lcd_m, sw_m;
  logic [3:0]  btn_m;

  always #5 clk = ~clk;

  lsu_mmio dut (
    .i_clk(clk), .i_reset(rst), .i_lsu_valid(lsu_valid), .i_lsu_wren(lsu_wren),
    .i_lsu_size(lsu_size), .i_lsu_addr(lsu_addr), .i_st_data(st_data),
    .i_io_sw(io_sw), .i_io_btn(io_btn), .o_ld_data(ld_data), .o_ld_valid(ld_valid),
    .o_misaligned(misaligned), .o_io_ledr(io_ledr), .o_io_ledg(io_ledg),
    .o_io_hex(io_hex), .o_io_lcd(io_lcd)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input logic w, input logic [2:0] sz, input logic [31:0] a);
    int n;
    bit ok;
    ok = w ? (sz <= 3'd2) : (sz inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    n  = 1 << sz[1:0];
    return ok && ((a % n) == 0);
  endfunction

  function automatic bit in_dmem(input logic [31:0] a);
    return (a >= 32'h2000) && (a <= 32'h3FFF);
  endfunction

  function automatic logic [31:0] m_word(input logic [31:0] a);
    if (in_dmem(a)) return {mm[a[12:0]+3], mm[a[12:0]+2], mm[a[12:0]+1], mm[a[12:0]]};
    case (a)
      32'h7000: return ledr_m;
      32'h7010: return ledg_m;
      32'h7020: return hexlo_m;
      32'h7024: return hexhi_m;
      32'h7030: return lcd_m;
      32'h7800: return sw_m;
      32'h7810: return {28'h0, btn_m};
      default:  return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] sz, input logic [31:0] a);
    int n;
    logic [63:0] v, mask;
    if (!legal(1'b0, sz, a)) return 32'h0;
    n    = 1 << sz[1:0];
    v    = 64'(m_word({a[31:2], 2'b00})) >> (8 * a[1:0]);
    mask = (64'd1 << (8 * n)) - 64'd1;
    v    = v & mask;
    if (!sz[2] && n < 4 && ((v >> (8 * n - 1)) & 64'd1) == 64'd1) v = v | ~mask;
    return v[31:0];
  endfunction

  function automatic void m_wbyte(input logic [31:0] b, input logic [7:0] val);
    int lane;
    lane = b % 4;
    if (in_dmem(b)) mm[b[12:0]] = val;
    else case (b - lane)
      32'h7000: ledr_m[8*lane +: 8]  = val;
      32'h7010: ledg_m[8*lane +: 8]  = val;
      32'h7020: hexlo_m[8*lane +: 8] = val;
      32'h7024: hexhi_m[8*lane +: 8] = val;
      32'h7030: lcd_m[8*lane +: 8]   = val;
      default: ;
    endcase
  endfunction

  function automatic void m_store(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
    if (!legal(1'b1, sz, a)) return;
    for (int i = 0; i < (1 << sz[1:0]); i++) m_wbyte(a + i, 8'((d >> (8 * i)) & 32'hFF));
  endfunction

  task automatic chk_io();
    chk("ledr", io_ledr, ledr_m);
    chk("ledg", io_ledg, ledg_m);
    chk("hex",  io_hex,  {hexhi_m, hexlo_m});
    chk("lcd",  io_lcd,  lcd_m);
  endtask

  task automatic step(input logic v, input logic w, input logic [2:0] sz,
                      input logic [31:0] a, input logic [31:0] d);
    logic ev, em;
    logic [31:0] ed;
    lsu_valid = v; lsu_wren = w; lsu_size = sz; lsu_addr = a; st_data = d;
    ev = v && !w;
    em = v && !legal(w, sz, a);
    ed = ev ? m_load(sz, a) : 32'h0;
    if (v && w) m_store(sz, a, d);
    @(posedge clk); #1;
    chk("ld_valid", ld_valid, ev);
    chk("misaligned", misaligned, em);
    if (ev) chk("ld_data", ld_data, ed);
    chk_io();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] a, base;
    logic [2:0]  sz;
    rst = 1'b1; lsu_valid = 0; lsu_wren = 0; lsu_size = 0; lsu_addr = 0; st_data = 0;
    io_sw = 0; io_btn = 0;
    ledr_m = 0; ledg_m = 0; hexlo_m = 0; hexhi_m = 0; lcd_m = 0; sw_m = 0; btn_m = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ld_valid", ld_valid, 1'b0);
    chk("rst_ld_data", ld_data, 32'h0);
    chk("rst_mis", misaligned, 1'b0);
    chk_io();
    rst = 1'b0;

    // Lane extraction and extension.
    step(1, 1, 3'b010, 32'h2000, 32'hDEADBEEF);
    step(1, 0, 3'b000, 32'h2003, 0); chk("lb", ld_data, 32'hFFFFFFDE);
    step(1, 0, 3'b100, 32'h2003, 0); chk("lbu", ld_data, 32'h000000DE);
    step(1, 0, 3'b001, 32'h2002, 0); chk("lh", ld_data, 32'hFFFFDEAD);
    step(1, 0, 3'b101, 32'h2000, 0); chk("lhu", ld_data, 32'h0000BEEF);
    step(1, 0, 3'b010, 32'h2000, 0); chk("lw", ld_data, 32'hDEADBEEF);

    // Byte store then immediate load.
    step(1, 1, 3'b010, 32'h2000, 32'h11223344);
    step(1, 1, 3'b000, 32'h2001, 32'hAABBCC55);
    step(1, 0, 3'b010, 32'h2000, 0); chk("sb_merge", ld_data, 32'h11225544);

    // Misalignment.
    step(1, 1, 3'b001, 32'h2001, 32'h0000FFFF); chk("sh_mis", misaligned, 1'b1);
    step(1, 0, 3'b010, 32'h2002, 0);
    chk("lw_mis", misaligned, 1'b1); chk("lw_mis_data", ld_data, 32'h0);
    step(1, 0, 3'b000, 32'h2000, 0); chk("lb_ok", misaligned, 1'b0);
    step(1, 0, 3'b010, 32'h2000, 0); chk("sh_dropped", ld_data, 32'h11225544);
    step(1, 0, 3'b011, 32'h2000, 0); chk("ill_size", misaligned, 1'b1);

    // I/O registers and synchronized inputs.
    step(1, 1, 3'b010, 32'h7000, 32'h0000A5A5); chk("ledr", io_ledr, 32'h0000A5A5);
    step(1, 1, 3'b000, 32'h7023, 32'h0000003F); chk("hex_b3", io_hex, 64'h000000003F000000);
    io_sw = 32'h12345678; sw_m = io_sw; io_btn = 4'hA; btn_m = io_btn;
    idle(); idle();
    step(1, 0, 3'b010, 32'h7800, 0); chk("sw_rd", ld_data, 32'h12345678);
    step(1, 0, 3'b010, 32'h7810, 0); chk("btn_rd", ld_data, 32'h0000000A);
    step(1, 1, 3'b010, 32'h7800, 32'hFFFFFFFF);
    step(1, 0, 3'b010, 32'h7800, 0); chk("sw_ro", ld_data, 32'h12345678);

    // Unmapped.
    step(1, 0, 3'b010, 32'h00012000, 0);
    chk("unmap_v", ld_valid, 1'b1); chk("unmap_d", ld_data, 32'h0); chk("unmap_m", misaligned, 1'b0);
    step(1, 1, 3'b010, 32'h5000, 32'hFFFFFFFF); chk("unmap_st_m", misaligned, 1'b0);
    step(1, 0, 3'b010, 32'h2000, 0); chk("unmap_st_dmem", ld_data, 32'h11225544);

    // Reset squashes the pending load and the concurrent store.
    lsu_valid = 1; lsu_wren = 0; lsu_size = 3'b010; lsu_addr = 32'h2000;
    @(posedge clk); #1;
    rst = 1'b1; lsu_wren = 1; st_data = 32'hCAFEF00D;
    #1; chk("rst_squash_v", ld_valid, 1'b0);
    @(posedge clk); #1;
    chk("rst2_v", ld_valid, 1'b0); chk("rst2_m", misaligned, 1'b0);
    rst = 1'b0;
    ledr_m = 0; ledg_m = 0; hexlo_m = 0; hexhi_m = 0; lcd_m = 0;
    chk_io();
    step(1, 0, 3'b010, 32'h2000, 0); chk("rst_dmem_kept", ld_data, 32'h11225544);

    // Randomized traffic over an initialized DMEM window and the I/O map.
    io_sw = $urandom; sw_m = io_sw; io_btn = 4'($urandom); btn_m = io_btn;
    for (int i = 0; i < 16; i++) step(1, 1, 3'b010, 32'h2000 + 4 * i, $urandom);
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: a = 32'h2000 + $urandom_range(0, 63);
        5, 6, 7: begin
          case ($urandom_range(0, 6))
            0: base = 32'h7000; 1: base = 32'h7010; 2: base = 32'h7020; 3: base = 32'h7024;
            4: base = 32'h7030; 5: base = 32'h7800; default: base = 32'h7810;
          endcase
          a = base + $urandom_range(0, 3);
        end
        8: a = 32'h00012000 | $urandom_range(0, 255);
        default: a = 32'h5000 + $urandom_range(0, 255);
      endcase
      sz = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0 && sz[1:0] != 2'b10) sz[2] = 1'b1;
      step($urandom_range(0, 9) != 0, 1'($urandom), sz, a, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
